ocram_two_port_arbiter: RTL and testbench

- Shares one single-port on-chip RAM (1024 x 32, byte-enabled, registered address, unregistered q) between two Avalon-MM masters.
- m0 is the processor instruction/data master; m1 is the boot loader / DMA master.
- Issues at most one RAM access per clock and returns read data one cycle later with readdatavalid, routed to the issuing master.
- Sits between the interconnect master ports and the OCRAM slave.

---
 rtl/ocram_two_port_arbiter_if.sv | 51 +++++
 rtl/ocram_two_port_arbiter.sv | 113 +++++++++++
 tb/tb_ocram_two_port_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ocram_two_port_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the single-port OCRAM.
// slave: arbiter view; master: view of the masters and RAM around the arbiter.
interface ocram_two_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W/8
);
    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        input  ram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        output ram_readdata
    );
endinterface

// File: rtl/ocram_two_port_arbiter.sv
// Two-master arbiter in front of a single-port OCRAM: one access per clock, 1-cycle read latency.
// Define OCRAM_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise m0 has fixed priority.
module ocram_two_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W/8
) (
    input  logic clk,
    input  logic reset_n,
    ocram_two_port_arbiter_if.slave bus
);
    logic              w_req0, w_req1;
    logic              w_gnt0, w_gnt1;
    logic              w_cs, w_wr, w_rd_acc;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;

    // r_active is low from reset until the first edge after release; it doubles as clken
    logic              r_active;
    logic              r_pend_rd, r_pend_id;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_wdata;

    assign w_req0 = bus.m0_read | bus.m0_write;
    assign w_req1 = bus.m1_read | bus.m1_write;

`ifdef OCRAM_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_active) begin
            if (w_req0 && w_req1) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = ~r_last_grant;
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last_grant <= 1'b1;
        else if (w_gnt0 || w_gnt1)
            r_last_grant <= w_gnt1;
    end
`else
    assign w_gnt0 = r_active & w_req0;
    assign w_gnt1 = r_active & w_req1 & ~w_req0;
`endif

    // Ungranted cycles keep presenting the last driven address/lanes/data
    always_comb begin
        w_addr  = r_addr;
        w_be    = r_be;
        w_wdata = r_wdata;
        if (w_gnt0) begin
            w_addr  = bus.m0_address;
            w_be    = bus.m0_byteenable;
            w_wdata = bus.m0_writedata;
        end else if (w_gnt1) begin
            w_addr  = bus.m1_address;
            w_be    = bus.m1_byteenable;
            w_wdata = bus.m1_writedata;
        end
    end

    assign w_cs     = w_gnt0 | w_gnt1;
    assign w_wr     = (w_gnt0 & bus.m0_write) | (w_gnt1 & bus.m1_write);
    // A write asserted together with a read wins; the read produces no response
    assign w_rd_acc = (w_gnt0 & bus.m0_read & ~bus.m0_write) |
                      (w_gnt1 & bus.m1_read & ~bus.m1_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= 1'b0;
            r_pend_rd <= 1'b0;
            r_pend_id <= 1'b0;
        end else begin
            r_active  <= 1'b1;
            r_pend_rd <= w_rd_acc;
            if (w_rd_acc)
                r_pend_id <= w_gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cs) begin
            r_addr  <= w_addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
        end
    end

    assign bus.ram_address    = w_addr;
    assign bus.ram_byteenable = w_be;
    assign bus.ram_writedata  = w_wdata;
    assign bus.ram_chipselect = w_cs;
    assign bus.ram_write      = w_wr;
    assign bus.ram_clken      = r_active;

    assign bus.m0_waitrequest   = ~r_active | (w_req0 & ~w_gnt0);
    assign bus.m1_waitrequest   = ~r_active | (w_req1 & ~w_gnt1);
    assign bus.m0_readdatavalid = r_pend_rd & ~r_pend_id;
    assign bus.m1_readdatavalid = r_pend_rd &  r_pend_id;
    assign bus.m0_readdata      = bus.ram_readdata;
    assign bus.m1_readdata      = bus.ram_readdata;
endmodule

// File: tb/tb_ocram_two_port_arbiter.sv
// Directed bench for ocram_two_port_arbiter: RAM model, per-cycle scoreboard, literal checks.
module tb_ocram_two_port_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    ocram_two_port_arbiter_if bus ();

    ocram_two_port_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [9:0] a);
        return 32'hA500_0000 ^ ({22'd0, a} * 32'h0001_0001);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    endtask

    // RAM device: registered address, unregistered q; stored as XOR against the power-up pattern
    bit   [31:0] ram_x [1024];
    logic [9:0]  ram_raddr;
    always @(posedge clk) begin
        if (bus.ram_clken && bus.ram_chipselect) begin
            if (bus.ram_write)
                for (int b = 0; b < 4; b++)
                    if (bus.ram_byteenable[b])
                        ram_x[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8] ^ pat(bus.ram_address)[8*b +: 8];
            ram_raddr <= bus.ram_address;
        end
    end
    assign bus.ram_readdata = ram_x[ram_raddr] ^ pat(ram_raddr);

    // Scoreboard: expected outputs from the arbitration rules and a shadow memory
    logic [31:0] shadow [1024];
    bit          m_active, m_last1, pend_v, pend_id, have_hold;
    logic [31:0] pend_data, h_wd, g_wd;
    logic [9:0]  h_addr, g_addr;
    logic [3:0]  h_be, g_be;
    bit          r0, r1, g_rd, g_wr;
    int          g;

    initial begin : model
        for (int i = 0; i < 1024; i++) shadow[i] = pat(i[9:0]);
        m_active = 0; m_last1 = 1; pend_v = 0; pend_id = 0; have_hold = 0;
        forever begin
            @(negedge clk); #2;
            if (!reset_n) begin
                chk("rst_wait0", bus.m0_waitrequest, 1);
                chk("rst_wait1", bus.m1_waitrequest, 1);
                chk("rst_rdv0", bus.m0_readdatavalid, 0);
                chk("rst_rdv1", bus.m1_readdatavalid, 0);
                chk("rst_cs", bus.ram_chipselect, 0);
                chk("rst_clken", bus.ram_clken, 0);
                m_active = 0; m_last1 = 1; pend_v = 0;
            end else begin
                chk("rdv0", bus.m0_readdatavalid, pend_v && !pend_id);
                chk("rdv1", bus.m1_readdatavalid, pend_v && pend_id);
                if (pend_v && !pend_id) chk("rdata0", bus.m0_readdata, pend_data);
                if (pend_v && pend_id)  chk("rdata1", bus.m1_readdata, pend_data);
                chk("clken", bus.ram_clken, m_active);
                r0 = bus.m0_read || bus.m0_write;
                r1 = bus.m1_read || bus.m1_write;
                g = -1;
                if (m_active) begin
`ifdef OCRAM_ARB_ROUND_ROBIN_EN
                    if (r0 && r1) g = m_last1 ? 0 : 1;
`else
                    if (r0 && r1) g = 0;
`endif
                    else if (r0) g = 0;
                    else if (r1) g = 1;
                end
                chk("wait0", bus.m0_waitrequest, !m_active || (r0 && g != 0));
                chk("wait1", bus.m1_waitrequest, !m_active || (r1 && g != 1));
                chk("cs", bus.ram_chipselect, g >= 0);
                pend_v = 0;
                if (g >= 0) begin
                    g_rd   = (g == 0) ? bus.m0_read : bus.m1_read;
                    g_wr   = (g == 0) ? bus.m0_write : bus.m1_write;
                    g_addr = (g == 0) ? bus.m0_address : bus.m1_address;
                    g_be   = (g == 0) ? bus.m0_byteenable : bus.m1_byteenable;
                    g_wd   = (g == 0) ? bus.m0_writedata : bus.m1_writedata;
                    chk("ram_write", bus.ram_write, g_wr);
                    chk("ram_addr", bus.ram_address, g_addr);
                    chk("ram_be", bus.ram_byteenable, g_be);
                    chk("ram_wd", bus.ram_writedata, g_wd);
                    if (g_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (g_be[b]) shadow[g_addr][8*b +: 8] = g_wd[8*b +: 8];
                    end else if (g_rd) begin
                        pend_v = 1; pend_id = (g == 1); pend_data = shadow[g_addr];
                    end
                    m_last1 = (g == 1);
                    have_hold = 1; h_addr = g_addr; h_be = g_be; h_wd = g_wd;
                end else begin
                    chk("ram_write_idle", bus.ram_write, 0);
                    if (m_active && have_hold) begin
                        chk("hold_addr", bus.ram_address, h_addr);
                        chk("hold_be", bus.ram_byteenable, h_be);
                        chk("hold_wd", bus.ram_writedata, h_wd);
                    end
                end
                m_active = 1;
            end
        end
    end

    task automatic drv(input int m, input bit rd, input bit wr, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
            bus.m0_byteenable = be; bus.m0_writedata = wd;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
            bus.m1_byteenable = be; bus.m1_writedata = wd;
        end
    endtask

    task automatic idle();
        drv(0, 0, 0, '0, '0, '0);
        drv(1, 0, 0, '0, '0, '0);
    endtask

    logic [31:0] w0 [4];
    logic [31:0] w1 [4];
    int c0, c1, cw;
    logic [9:0] a;
    logic [31:0] exp_d;

    initial begin : stim
        idle();
        reset_n = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        #3 chk("rel_wait0", bus.m0_waitrequest, 1);
        chk("rel_clken", bus.ram_clken, 0);

        // m0 write then read back
        @(negedge clk); drv(0, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF);
        @(negedge clk); drv(0, 1, 0, 10'h005, 4'hF, 32'h0);
        #3 chk("t1_wait0", bus.m0_waitrequest, 0);
        @(negedge clk); idle();
        #3 chk("t1_rdv0", bus.m0_readdatavalid, 1);
        chk("t1_rdata0", bus.m0_readdata, 32'hDEADBEEF);
        chk("t1_rdv1", bus.m1_readdatavalid, 0);
        @(negedge clk);
        #3 chk("t1_rdv0_once", bus.m0_readdatavalid, 0);

        // m1 partial write
        @(negedge clk); drv(1, 0, 1, 10'h3FF, 4'hF, 32'h11223344);
        @(negedge clk); drv(1, 0, 1, 10'h3FF, 4'h5, 32'hAABBCCDD);
        @(negedge clk); drv(1, 1, 0, 10'h3FF, 4'hF, 32'h0);
        @(negedge clk); idle();
        #3 chk("t2_rdv1", bus.m1_readdatavalid, 1);
        chk("t2_rdata1", bus.m1_readdata, 32'h11BB33DD);

        // conflict, last winner was m1
        c0 = 0; c1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                drv(0, 1, 0, 10'h010, 4'hF, 32'h0);
                drv(1, 1, 0, 10'h020, 4'hF, 32'h0);
            end else idle();
            #3;
            if (i < 4) begin w0[i] = bus.m0_waitrequest; w1[i] = bus.m1_waitrequest; end
            if (i > 0) begin c0 += bus.m0_readdatavalid; c1 += bus.m1_readdatavalid; end
        end
        for (int i = 0; i < 4; i++) begin
`ifdef OCRAM_ARB_ROUND_ROBIN_EN
            chk("t3_wait0", w0[i], i % 2);
            chk("t3_wait1", w1[i], 1 - (i % 2));
`else
            chk("t3_wait0", w0[i], 0);
            chk("t3_wait1", w1[i], 1);
`endif
        end
`ifdef OCRAM_ARB_ROUND_ROBIN_EN
        chk("t3_cnt0", c0, 2);
        chk("t3_cnt1", c1, 2);
`else
        chk("t3_cnt0", c0, 4);
        chk("t3_cnt1", c1, 0);
`endif

        // simultaneous read+write: write wins, no response
        @(negedge clk); drv(0, 1, 1, 10'h007, 4'hF, 32'hCAFEF00D);
        @(negedge clk); drv(0, 1, 0, 10'h007, 4'hF, 32'h0);
        #3 chk("t4_no_rdv0", bus.m0_readdatavalid, 0);
        @(negedge clk); idle();
        #3 chk("t4_rdv0", bus.m0_readdatavalid, 1);
        chk("t4_rdata0", bus.m0_readdata, 32'hCAFEF00D);

        // m1 streaming reads 0x000..0x00F
        c1 = 0; cw = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i < 16) drv(1, 1, 0, 10'(i), 4'hF, 32'h0); else idle();
            #3;
            if (i < 16) cw += bus.m1_waitrequest;
            if (i > 0) begin
                c1 += bus.m1_readdatavalid;
                a = 10'(i - 1);
                exp_d = (a == 10'h005) ? 32'hDEADBEEF : (a == 10'h007) ? 32'hCAFEF00D : pat(a);
                chk("t5_rdata1", bus.m1_readdata, exp_d);
            end
        end
        chk("t5_rdv_count", c1, 16);
        chk("t5_wait_count", cw, 0);

        // reset lands while a read is in flight
        @(negedge clk); drv(0, 1, 0, 10'h010, 4'hF, 32'h0);
        #3 chk("t6_accept", bus.m0_waitrequest, 0);
        reset_n = 0;
        @(negedge clk);
        #3 chk("t6_rdv0", bus.m0_readdatavalid, 0);
        chk("t6_wait0", bus.m0_waitrequest, 1);
        chk("t6_cs", bus.ram_chipselect, 0);
        @(negedge clk); reset_n = 1;
        #3 chk("t6_rel_wait0", bus.m0_waitrequest, 1);
        chk("t6_rel_rdv0", bus.m0_readdatavalid, 0);
        @(negedge clk);
        #3 chk("t6_go_wait0", bus.m0_waitrequest, 0);
        chk("t6_go_cs", bus.ram_chipselect, 1);
        @(negedge clk); idle();
        #3 chk("t6_rdv0_after", bus.m0_readdatavalid, 1);
        chk("t6_rdata0_after", bus.m0_readdata, pat(10'h010));

        repeat (3) @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
